// File: rtl/ram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// ram_stream_reader_if
// Output stream of the RAM stream reader.
//   m_data  : beat payload                (reader -> sink)
//   m_valid : beat present on m_data      (reader -> sink)
//   m_last  : final beat of the transfer  (reader -> sink), qualified by m_valid
//   m_ready : sink accepts the beat       (sink -> reader)
// master modport is the reader side, slave modport is the sink side.
// ---------------------------------------------------------------------------
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
// Reads 'length' consecutive words from a synchronous RAM read port starting
// at 'base_addr' (wrapping modulo 2^ADDR_WIDTH) and emits them as a
// valid/ready stream with m_last on the final beat.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : transfer request, sampled only while idle
//   base_addr   : first word address, sampled with start
//   length      : word count 0..2^ADDR_WIDTH, sampled with start
//   busy        : transfer in progress
//   done        : one-cycle completion pulse
//   rd_addr     : registered RAM read address
//   rd_data     : RAM read data, valid one cycle after rd_addr
//   m           : output stream (master side)
// ---------------------------------------------------------------------------
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  ram_stream_reader_if.master   m
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // issue stage: rd_addr holds a live read while iss_vld_p0 is set
  logic                  iss_vld_p0;
  logic [ADDR_WIDTH:0]   issue_left;
  // capture stage: rd_data belongs to the read issued last cycle
  logic                  cap_vld_p1;

  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wptr, rptr;
  logic [2:0]            fifo_cnt;
  logic [ADDR_WIDTH:0]   beats_left;

  logic                  load;
  logic                  issue;
  logic                  done_d;
  logic                  push, pop;
  logic [2:0]            pending;

  assign push    = cap_vld_p1;
  assign pop     = m.m_valid & m.m_ready;
  // Buffered words plus reads still travelling through the RAM; pops are
  // ignored here so the credit is conservative and the FIFO can never overflow.
  assign pending = fifo_cnt + {2'b00, iss_vld_p0} + {2'b00, cap_vld_p1};

  assign busy      = (state_q != IDLE);
  assign m.m_valid = (fifo_cnt != 3'd0);
  assign m.m_data  = m.m_valid ? fifo_mem[rptr] : '0;
  assign m.m_last  = m.m_valid & (beats_left == {{ADDR_WIDTH{1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d = READ;
            load    = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue_left == '0)     state_d = DRAIN;
        else if (pending < 3'd4)  issue   = 1'b1;
      end
      DRAIN: begin
        if (pop && m.m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr    <= '0;
      iss_vld_p0 <= 1'b0;
      issue_left <= '0;
      cap_vld_p1 <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_cnt   <= '0;
      beats_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= done_d;

      // issue stage
      iss_vld_p0 <= load | issue;
      if (load) begin
        rd_addr    <= base_addr;
        issue_left <= length - 1'b1;
      end else if (issue) begin
        rd_addr    <= rd_addr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end

      // capture stage
      cap_vld_p1 <= iss_vld_p0;

      // output FIFO
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (load)     beats_left <= length;
      else if (pop) beats_left <= beats_left - 1'b1;
    end
  end

  // FIFO storage is data only; occupancy gates every read of it
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= rd_data;
  end

endmodule
